alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial 24-bit ALU sequencer that drives one external ALU1bit slice over successive cycles, presenting one operand bit pair and the slice controls per cycle. It collects the slice result and carry, and assembles the full-width result and flags. It is the controlling side of the 1-bit slice interface. It gives the datapath an area-minimal ALU option: one slice, a counter, shift registers and a small FSM.

## Interface
- WIDTH, 24, operand/result width in bits (≥ 2)
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- A  in  WIDTH  operand A; captured on accepted Start
- B  in  WIDTH  operand B; captured on accepted Start
- ALUCtrl  in  5  {AInvert, BInvert, Op[2:0]}; captured on accepted Start
- SliceA, SliceB  out  1  current operand bits to slice
- SliceCIN  out  1  carry into slice
- SliceAInvert, SliceBInvert  out  1  invert controls to slice
- SliceLess  out  1  Less input to slice
- SliceOp  out  3  slice operation select
- SliceResult  in  1  slice combinational result
- SliceCarryOut  in  1  slice combinational carry-out
- Busy  out  1  high from accept until Done
- Done  out  1  one-cycle pulse; Result and flags valid
- Result  out  WIDTH  assembled result; held until next accepted Start
- Zero, Overflow, CarryOut  out  1  flags; held with Result

## Operation
- Op encoding: 000 AND, 001 OR, 010 ADD, 011 SLT, 100 XOR. 101–111 select constant-0 mux inputs, so Result is 0.
- FSM states: IDLE → RUN → (LESS if Op=SLT) → DONE → IDLE.
- IDLE:
  - All Slice* outputs are 0.
  - Start=1 captures A, B and ALUCtrl, clears the bit counter, clears the result shift register, and sets Busy.
- RUN, bit i = 0..WIDTH-1 (LSB first):
  - SliceA = A[i], SliceB = B[i].
  - SliceAInvert and SliceBInvert come from the captured ALUCtrl.
  - SliceCIN = BInvert at i=0; otherwise the registered carry.
  - SliceOp = captured Op, except SLT, which drives 010 (ADD) in RUN.
  - SliceLess = 0.
  - Each edge shifts SliceResult into Result[i] and registers SliceCarryOut.
- At i=WIDTH-1:
  - CarryOut ← SliceCarryOut.
  - Overflow ← SliceCIN XOR SliceCarryOut.
  - For SLT, set ← SliceResult XOR Overflow.
- LESS (SLT only): a second WIDTH-cycle pass.
  - SliceOp = 011 and carry is handled as in RUN.
  - SliceLess = set at i=0, 0 elsewhere.
  - Result is rebuilt from SliceResult, giving {0…0, set}.
- DONE: Done=1 for one cycle, Busy=0, Zero = (Result==0). Next state is IDLE.
- Start while Busy is ignored; it is not queued.
- Reset at any time, including mid-pass, forces IDLE and zeroes every output. An operation in flight is lost.

## Timing
- Reset values: Busy=0, Done=0, Result=0, Zero=0, Overflow=0, CarryOut=0, all Slice* = 0.
- Start accepted at edge 0; RUN occupies cycles 1..WIDTH.
- Done is high in cycle WIDTH+1 (cycle 25 for WIDTH=24) for non-SLT ops, and in cycle 2·WIDTH+1 (cycle 49) for SLT.
- Earliest next Start is accepted in the cycle after Done. Throughput is one op per WIDTH+2 cycles (non-SLT).
- The slice is purely combinational. Slice* outputs are registered state, and SliceResult/SliceCarryOut are sampled on the same edge.
- Overflow and CarryOut are meaningful only for ADD/SUB. For other ops they hold the values computed during the pass.

## Configuration
- ALU_SERIAL_FLAGS_EN
  - Defined: the Zero, Overflow and CarryOut registers and logic are built as described.
  - Undefined: the flag registers are omitted and the three ports are tied to 0.
  - SLT still computes Overflow internally for `set`.
  - Ports and latency are identical in both builds.

## Structure
- Package alu_pkg holds:
  - Op encodings (OP_AND, OP_OR, OP_ADD, OP_SLT, OP_XOR)
  - the state enum (S_IDLE, S_RUN, S_LESS, S_DONE)
  - the default width constant (24)
  - field positions of ALUCtrl
- One natural sub-module: serial_shreg, a WIDTH-bit load/shift-right register with serial output bit and serial-in at MSB. It is instantiated for A, B and Result.
- The ALU1bit slice is instantiated by the parent datapath, not inside this block.

## Test plan
- ADD A=0x000005, B=0x000003, ALUCtrl=00_010 → Result=0x000008, CarryOut=0, Zero=0; Done in cycle 25.
- SUB A=0x000005, B=0x000003, ALUCtrl=01_010 → Result=0x000002, CarryOut=1, Overflow=0.
- SLT A=0xFFFFFF, B=0x000001, ALUCtrl=01_011 → Result=0x000001, Done in cycle 49. Swapped operands → Result=0x000000, Zero=1.
- ADD A=0x7FFFFF, B=0x000001 → Result=0x800000, Overflow=1. XOR A=B=0xAAAAAA → Result=0, Zero=1. AND with AInvert=BInvert=1, A=B=0 (NOR) → 0xFFFFFF.
- Start pulsed at cycle 5 of RUN → ignored; the original op completes unchanged. Op=110 → Result=0.
- Reset asserted at bit 10 of RUN → Busy, Result and all Slice* = 0 immediately. After release, ADD 1+1 → Result=0x000002 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, op encodings and FSM state type for the bit-serial ALU sequencer.
package alu_pkg;

  localparam int ALU_WIDTH = 24;
  localparam int OP_W      = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SLT = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;

  // ALUCtrl = {AInvert, BInvert, Op[2:0]}
  localparam int CTRL_AINV_BIT = 4;
  localparam int CTRL_BINV_BIT = 3;
  localparam int CTRL_OP_MSB   = 2;
  localparam int CTRL_OP_LSB   = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LESS = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic overflow_bit(input logic cin_msb, input logic cout_msb);
    return cin_msb ^ cout_msb;
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Bit-serial link between the sequencer (master) and one combinational ALU1bit slice (slave).
interface alu_serial_ctrl_if;
  import alu_pkg::*;

  logic            a;
  logic            b;
  logic            cin;
  logic            a_invert;
  logic            b_invert;
  logic            less;
  logic [OP_W-1:0] op;
  logic            result;
  logic            carry_out;

  modport master (
    output a, b, cin, a_invert, b_invert, less, op,
    input  result, carry_out
  );

  modport slave (
    input  a, b, cin, a_invert, b_invert, less, op,
    output result, carry_out
  );

endinterface

// File: rtl/alu_serial_ctrl_serial_shreg.sv
// Load / shift-right register: serial-in at the MSB, serial-out from the LSB.
module serial_shreg
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  logic [WIDTH-1:0] q_r;

  // Load has priority over shift so a pass can end by clearing the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= load_data;
    end else if (shift) begin
      q_r <= {sin, q_r[WIDTH-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign q    = q_r;
  assign sout = q_r[0];

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer driving one external ALU1bit slice, LSB first.
// Build option ALU_SERIAL_FLAGS_EN: when defined, Zero/Overflow/CarryOut are registered; otherwise tied to 0.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic [4:0]                alu_ctrl,
  alu_serial_ctrl_if.master         slice,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          result,
  output logic                      zero,
  output logic                      overflow,
  output logic                      carry_out
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e          state_r, state_s;
  logic [CW-1:0]   cnt_r;
  logic [OP_W-1:0] op_r;
  logic [OP_W-1:0] slice_op_r;
  logic            a_inv_r, b_inv_r, cin_r, less_r, busy_r, done_r;

  logic accept_s, step_s, last_s, is_slt_s, run_last_s, pass_end_s, ovf_s, set_s;
  logic [WIDTH-1:0] a_q_s, b_q_s, res_q_s;
  logic a_sout_s, b_sout_s, res_sout_s;
  logic unused_s;

  assign accept_s   = (state_r == S_IDLE) && start;
  assign step_s     = (state_r == S_RUN) || (state_r == S_LESS);
  assign last_s     = (cnt_r == LAST_IDX);
  assign is_slt_s   = (op_r == OP_SLT);
  assign run_last_s = (state_r == S_RUN) && last_s;
  // An SLT add pass rolls into the LESS pass instead of finishing.
  assign pass_end_s = step_s && last_s && !(run_last_s && is_slt_s);
  assign ovf_s      = overflow_bit(slice.cin, slice.carry_out);
  assign set_s      = slice.result ^ ovf_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_RUN;
        else       state_s = S_IDLE;
      end
      S_RUN: begin
        if (last_s && is_slt_s) state_s = S_LESS;
        else if (last_s)        state_s = S_DONE;
        else                    state_s = S_RUN;
      end
      S_LESS: begin
        if (last_s) state_s = S_DONE;
        else        state_s = S_LESS;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Operand registers rotate so the LESS pass sees the operands again; cleared when the op ends.
  serial_shreg #(.WIDTH(WIDTH)) u_a_shreg (
    .clk(clk), .rst_n(rst_n),
    .load(accept_s || pass_end_s), .shift(step_s),
    .load_data(accept_s ? a : '0), .sin(a_sout_s),
    .q(a_q_s), .sout(a_sout_s)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b_shreg (
    .clk(clk), .rst_n(rst_n),
    .load(accept_s || pass_end_s), .shift(step_s),
    .load_data(accept_s ? b : '0), .sin(b_sout_s),
    .q(b_q_s), .sout(b_sout_s)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_res_shreg (
    .clk(clk), .rst_n(rst_n),
    .load(accept_s), .shift(step_s),
    .load_data('0), .sin(slice.result),
    .q(res_q_s), .sout(res_sout_s)
  );

  assign unused_s = ^{a_q_s[WIDTH-1:1], b_q_s[WIDTH-1:1], res_sout_s};

  // Slice control registers, bit counter and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      op_r       <= '0;
      slice_op_r <= '0;
      a_inv_r    <= 1'b0;
      b_inv_r    <= 1'b0;
      cin_r      <= 1'b0;
      less_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else if (accept_s) begin
      cnt_r      <= '0;
      op_r       <= alu_ctrl[CTRL_OP_MSB:CTRL_OP_LSB];
      slice_op_r <= (alu_ctrl[CTRL_OP_MSB:CTRL_OP_LSB] == OP_SLT) ? OP_ADD
                                                                   : alu_ctrl[CTRL_OP_MSB:CTRL_OP_LSB];
      a_inv_r    <= alu_ctrl[CTRL_AINV_BIT];
      b_inv_r    <= alu_ctrl[CTRL_BINV_BIT];
      cin_r      <= alu_ctrl[CTRL_BINV_BIT];
      less_r     <= 1'b0;
      busy_r     <= 1'b1;
    end else if (pass_end_s) begin
      cnt_r      <= '0;
      op_r       <= op_r;
      slice_op_r <= '0;
      a_inv_r    <= 1'b0;
      b_inv_r    <= 1'b0;
      cin_r      <= 1'b0;
      less_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else if (run_last_s) begin
      cnt_r      <= '0;
      op_r       <= op_r;
      slice_op_r <= OP_SLT;
      a_inv_r    <= a_inv_r;
      b_inv_r    <= b_inv_r;
      cin_r      <= b_inv_r;
      less_r     <= set_s;
      busy_r     <= busy_r;
    end else if (step_s) begin
      cnt_r      <= cnt_r + CW'(1);
      op_r       <= op_r;
      slice_op_r <= slice_op_r;
      a_inv_r    <= a_inv_r;
      b_inv_r    <= b_inv_r;
      cin_r      <= slice.carry_out;
      less_r     <= 1'b0;
      busy_r     <= busy_r;
    end else begin
      cnt_r      <= cnt_r;
      op_r       <= op_r;
      slice_op_r <= slice_op_r;
      a_inv_r    <= a_inv_r;
      b_inv_r    <= b_inv_r;
      cin_r      <= cin_r;
      less_r     <= less_r;
      busy_r     <= busy_r;
    end
  end

  // Done pulse for the cycle after the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= pass_end_s;
    end
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic zero_r, overflow_r, carry_out_r;

  // Flags: carry/overflow from the MSB of the add pass, zero from the final assembled result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      carry_out_r <= 1'b0;
    end else if (accept_s) begin
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      carry_out_r <= 1'b0;
    end else begin
      if (run_last_s) begin
        overflow_r  <= ovf_s;
        carry_out_r <= slice.carry_out;
      end else begin
        overflow_r  <= overflow_r;
        carry_out_r <= carry_out_r;
      end
      if (pass_end_s) begin
        zero_r <= ({slice.result, res_q_s[WIDTH-1:1]} == '0);
      end else begin
        zero_r <= zero_r;
      end
    end
  end

  assign zero      = zero_r;
  assign overflow  = overflow_r;
  assign carry_out = carry_out_r;
`else
  assign zero      = 1'b0;
  assign overflow  = 1'b0;
  assign carry_out = 1'b0;
`endif

  assign slice.a        = a_sout_s;
  assign slice.b        = b_sout_s;
  assign slice.cin      = cin_r;
  assign slice.a_invert = a_inv_r;
  assign slice.b_invert = b_inv_r;
  assign slice.less     = less_r;
  assign slice.op       = slice_op_r;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = res_q_s;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Randomized self-checking bench for alu_serial_ctrl with a behavioural ALU1bit slice and word-level reference model.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = ALU_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [4:0]   ctrl = '0;
  logic         busy, done, zero, overflow, carry_out;
  logic [W-1:0] result;
  logic         slice_ea, slice_eb;

  int checks = 0;
  int fails  = 0;

  alu_serial_ctrl_if sl ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a_in), .b(b_in), .alu_ctrl(ctrl),
    .slice(sl.master),
    .busy(busy), .done(done), .result(result),
    .zero(zero), .overflow(overflow), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // Behavioural one-bit ALU slice.
  always_comb begin
    slice_ea     = sl.a ^ sl.a_invert;
    slice_eb     = sl.b ^ sl.b_invert;
    sl.carry_out = (slice_ea & slice_eb) | (slice_ea & sl.cin) | (slice_eb & sl.cin);
    case (sl.op)
      3'b000:  sl.result = slice_ea & slice_eb;
      3'b001:  sl.result = slice_ea | slice_eb;
      3'b010:  sl.result = slice_ea ^ slice_eb ^ sl.cin;
      3'b011:  sl.result = sl.less;
      3'b100:  sl.result = slice_ea ^ slice_eb;
      default: sl.result = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-level reference: two's-complement add/sub with signed overflow, bitwise ops, SLT.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c,
                                output logic [W-1:0] r, output logic z, output logic v, output logic co);
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W:0]   s;
    ea = c[4] ? ~a : a;
    eb = c[3] ? ~b : b;
    s  = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, c[3]};
    co = s[W];
    v  = (ea[W-1] == eb[W-1]) && (s[W-1] != ea[W-1]);
    case (c[2:0])
      3'd0:    r = ea & eb;
      3'd1:    r = ea | eb;
      3'd2:    r = s[W-1:0];
      3'd3:    r = {{(W-1){1'b0}}, s[W-1] ^ v};
      3'd4:    r = ea ^ eb;
      default: r = '0;
    endcase
    z = (r == '0);
  endfunction

  function automatic logic [8:0] slice_bus();
    return {sl.a, sl.b, sl.cin, sl.a_invert, sl.b_invert, sl.less, sl.op};
  endfunction

  // Issue one op at a negedge, optionally poke Start mid-run, check latency, result, flags and idle state.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c, input int poke);
    logic [W-1:0] er;
    logic ez, ev, ec;
    int n;
    int lat;
    model(a, b, c, er, ez, ev, ec);
`ifndef ALU_SERIAL_FLAGS_EN
    ez = 1'b0; ev = 1'b0; ec = 1'b0;
`endif
    lat = (c[2:0] == OP_SLT) ? 2*W + 1 : W + 1;
    a_in = a; b_in = b; ctrl = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); ctrl = 5'($urandom);
    n = 1;
    check("busy_run", busy, 1);
    while (!done && n < 4*W) begin
      start = (n == poke);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency", n, lat);
    check("result", result, er);
    check("zero", zero, ez);
    check("overflow", overflow, ev);
    check("carry_out", carry_out, ec);
    check("busy_done", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("result_hold", result, er);
    check("slice_idle", slice_bus(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, overflow, carry_out}, 0);
    check("rst_slice", slice_bus(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(24'h000005, 24'h000003, 5'b00_010, 0);
    do_op(24'h000005, 24'h000003, 5'b01_010, 0);
    do_op(24'hFFFFFF, 24'h000001, 5'b01_011, 0);
    do_op(24'h000001, 24'hFFFFFF, 5'b01_011, 0);
    do_op(24'h7FFFFF, 24'h000001, 5'b00_010, 0);
    do_op(24'hAAAAAA, 24'hAAAAAA, 5'b00_100, 0);
    do_op(24'h000000, 24'h000000, 5'b11_000, 0);
    do_op(24'h123456, 24'h00F0F0, 5'b00_001, 5);
    do_op(24'h123456, 24'h654321, 5'b00_110, 0);
    do_op(24'h800000, 24'h000001, 5'b01_010, 0);

    // Reset in the middle of a pass (bit 10 of RUN).
    a_in = 24'hFFFFFF; b_in = 24'h000000; ctrl = 5'b00_001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_slice", slice_bus(), 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(24'h000001, 24'h000001, 5'b00_010, 0);

    for (int i = 0; i < 30; i++) begin
      do_op(W'($urandom), W'($urandom), 5'($urandom_range(0, 31)), (i % 4 == 0) ? 3 + i : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
